// File: rtl/mem_burst_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mem_burst_pkg
//  Description : Shared types and constants for the line-to-burst responder.
//                Holds the FSM state encoding, the default line and beat
//                widths, the beats-per-line count and the number of byte
//                offset bits inside one line.
//  Revision    : 1.0 - initial release
// ============================================================================
package mem_burst_pkg;

  // Default geometry: a 256-bit cache line moved as four 64-bit beats.
  localparam int unsigned LB_LINE_W      = 256;
  localparam int unsigned LB_BURST_W     = 64;
  localparam int unsigned LB_BEATS       = LB_LINE_W / LB_BURST_W;

  // Address bits that select a byte within a line; zeroed on capture.
  localparam int unsigned LB_OFFSET_BITS = $clog2(LB_LINE_W / 8);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } lb_state_t;

endpackage : mem_burst_pkg
`default_nettype wire

// File: rtl/line_burst_responder.sv
`default_nettype none
// ============================================================================
//  Module      : line_burst_responder
//  Description : Responder side of the cache's physical-memory line port.
//                Accepts one line request at a time, serialises it into a
//                fixed-length burst of ascending beats (beat 0 first), gathers
//                returned read beats into a line, and answers the cache with
//                a one-cycle pmem_resp.
//  Revision    : 1.0 - initial release
//
//  Ports
//    clk            in   clock
//    rst            in   synchronous active-high reset
//    pmem_read      in   line read request, level, held until pmem_resp
//    pmem_write     in   line write request, level, held until pmem_resp
//    pmem_address   in   line address (ADDR_W), stable while request held
//    pmem_wdata     in   write line (LINE_W), stable while pmem_write held
//    pmem_rdata     out  assembled read line (LINE_W), registered
//    pmem_resp      out  one-cycle completion pulse
//    burst_address  out  line-aligned burst address (ADDR_W)
//    burst_read     out  burst read request
//    burst_write    out  burst write request
//    burst_wdata    out  current write beat (BURST_W)
//    burst_rdata    in   current read beat (BURST_W)
//    burst_resp     in   beat accepted / valid this cycle
// ============================================================================
module line_burst_responder
  import mem_burst_pkg::*;
#(
  parameter int unsigned LINE_W  = LB_LINE_W,
  parameter int unsigned BURST_W = LB_BURST_W,
  parameter int unsigned ADDR_W  = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               pmem_read,
  input  logic               pmem_write,
  input  logic [ADDR_W-1:0]  pmem_address,
  input  logic [LINE_W-1:0]  pmem_wdata,
  output logic [LINE_W-1:0]  pmem_rdata,
  output logic               pmem_resp,
  output logic [ADDR_W-1:0]  burst_address,
  output logic               burst_read,
  output logic               burst_write,
  output logic [BURST_W-1:0] burst_wdata,
  input  logic [BURST_W-1:0] burst_rdata,
  input  logic               burst_resp
);

  localparam int unsigned BEATS       = LINE_W / BURST_W;
  localparam int unsigned OFFSET_BITS = $clog2(LINE_W / 8);
  localparam int unsigned CNT_W       = (BEATS > 1) ? $clog2(BEATS) : 1;

  localparam logic [CNT_W-1:0]  LAST_BEAT = CNT_W'(BEATS - 1);
  // Clears the byte-offset bits so the burst always starts on a line boundary.
  localparam logic [ADDR_W-1:0] ADDR_MASK = ~(ADDR_W'((64'd1 << OFFSET_BITS) - 64'd1));

  lb_state_t          state_q, state_d;
  logic [CNT_W-1:0]   cnt_q,   cnt_d;
  logic [ADDR_W-1:0]  addr_q,  addr_d;
  logic [LINE_W-1:0]  wdata_q, wdata_d;
  logic [LINE_W-1:0]  rdata_q, rdata_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;

    unique case (state_q)
      IDLE: begin
        // Write has priority when both requests are raised together.
        if (pmem_write) begin
          addr_d  = pmem_address & ADDR_MASK;
          wdata_d = pmem_wdata;
          cnt_d   = '0;
          state_d = WRITE;
        end else if (pmem_read) begin
          addr_d  = pmem_address & ADDR_MASK;
          cnt_d   = '0;
          state_d = READ;
        end
      end

      READ: begin
        // Cycles without burst_resp are stalls: nothing moves.
        if (burst_resp) begin
          rdata_d[cnt_q*BURST_W +: BURST_W] = burst_rdata;
          if (cnt_q == LAST_BEAT) begin
            cnt_d   = '0;
            state_d = DONE;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end

      WRITE: begin
        if (burst_resp) begin
          if (cnt_q == LAST_BEAT) begin
            cnt_d   = '0;
            state_d = DONE;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // All handshake outputs decode directly from the registered state, so they
  // are glitch-free and drop to zero together on reset.
  assign pmem_resp     = (state_q == DONE);
  assign burst_read    = (state_q == READ);
  assign burst_write   = (state_q == WRITE);
  assign burst_address = addr_q;
  assign burst_wdata   = wdata_q[cnt_q*BURST_W +: BURST_W];
  assign pmem_rdata    = rdata_q;

endmodule : line_burst_responder
`default_nettype wire

// File: tb/tb_line_burst_responder.sv
`default_nettype none
// ============================================================================
//  Module      : tb_line_burst_responder
//  Description : Directed self-checking bench for line_burst_responder.
//                Inputs change and outputs are sampled on the falling edge;
//                the design updates on the rising edge.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_line_burst_responder;

  logic         clk = 1'b0;
  logic         rst;
  logic         pmem_read;
  logic         pmem_write;
  logic [31:0]  pmem_address;
  logic [255:0] pmem_wdata;
  logic [255:0] pmem_rdata;
  logic         pmem_resp;
  logic [31:0]  burst_address;
  logic         burst_read;
  logic         burst_write;
  logic [63:0]  burst_wdata;
  logic [63:0]  burst_rdata;
  logic         burst_resp;

  int n_vec = 0;
  int n_err = 0;
  int resp_seen = 0;

  always #5 clk = ~clk;

  line_burst_responder #(
    .LINE_W (256),
    .BURST_W(64),
    .ADDR_W (32)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .pmem_read    (pmem_read),
    .pmem_write   (pmem_write),
    .pmem_address (pmem_address),
    .pmem_wdata   (pmem_wdata),
    .pmem_rdata   (pmem_rdata),
    .pmem_resp    (pmem_resp),
    .burst_address(burst_address),
    .burst_read   (burst_read),
    .burst_write  (burst_write),
    .burst_wdata  (burst_wdata),
    .burst_rdata  (burst_rdata),
    .burst_resp   (burst_resp)
  );

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Advance to the next falling edge, tallying completion pulses seen there.
  task automatic tick();
    @(negedge clk);
    if (pmem_resp === 1'b1) resp_seen++;
  endtask

  localparam logic [63:0] B1 = 64'h1111_1111_1111_1111;
  localparam logic [63:0] B2 = 64'h2222_2222_2222_2222;
  localparam logic [63:0] B3 = 64'h3333_3333_3333_3333;
  localparam logic [63:0] B4 = 64'h4444_4444_4444_4444;
  localparam logic [63:0] W0 = 64'hC0C0_C0C0_0000_0C00;
  localparam logic [63:0] W1 = 64'hD1D1_D1D1_0000_0D11;
  localparam logic [63:0] W2 = 64'hD2D2_D2D2_0000_0D22;
  localparam logic [63:0] W3 = 64'hD3D3_D3D3_0000_0D33;
  localparam logic [63:0] E0 = 64'hA5A5_0000_0000_00E0;
  localparam logic [63:0] E1 = 64'h5A5A_0000_0000_00E1;
  localparam logic [63:0] E2 = 64'hF00F_0000_0000_00E2;
  localparam logic [63:0] E3 = 64'h0FF0_0000_0000_00E3;
  localparam logic [63:0] JUNK = 64'hDEAD_BEEF_DEAD_BEEF;

  logic [63:0] rd_beats[4];
  logic [63:0] wr_beats[4];
  logic [63:0] gap_beats[4];
  logic        gap_pat[7];

  initial begin
    rd_beats  = '{B1, B2, B3, B4};
    wr_beats  = '{W0, W1, W2, W3};
    gap_beats = '{E0, E1, E2, E3};
    gap_pat   = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};

    rst = 1'b1; pmem_read = 1'b0; pmem_write = 1'b0;
    pmem_address = '0; pmem_wdata = '0; burst_rdata = '0; burst_resp = 1'b0;
    tick(); tick();

    // ---------------- reset state ----------------
    check("rst_pmem_resp",   256'(pmem_resp),     256'd0);
    check("rst_burst_read",  256'(burst_read),    256'd0);
    check("rst_burst_write", 256'(burst_write),   256'd0);
    check("rst_burst_addr",  256'(burst_address), 256'd0);
    check("rst_burst_wdata", 256'(burst_wdata),   256'd0);
    check("rst_pmem_rdata",  pmem_rdata,          256'd0);
    rst = 1'b0;
    tick();

    // ---------------- 1: read, burst_resp tied high ----------------
    pmem_read = 1'b1; pmem_address = 32'h0000_1234; burst_resp = 1'b1; burst_rdata = JUNK;
    tick();                                   // cycle 1
    for (int k = 0; k < 4; k++) begin
      burst_rdata = rd_beats[k];
      check($sformatf("rd_burst_read_%0d", k), 256'(burst_read), 256'd1);
      check($sformatf("rd_resp_low_%0d", k),   256'(pmem_resp),  256'd0);
      tick();
    end
    // cycle 5
    check("rd_pmem_resp",   256'(pmem_resp),     256'd1);
    check("rd_burst_addr",  256'(burst_address), 256'h0000_1220);
    check("rd_burst_read_done", 256'(burst_read), 256'd0);
    check("rd_pmem_rdata",  pmem_rdata, {B4, B3, B2, B1});
    pmem_read = 1'b0;                         // stray burst_resp stays high
    tick();
    check("rd_idle_resp",   256'(pmem_resp),  256'd0);
    check("rd_idle_read",   256'(burst_read), 256'd0);
    check("rd_rdata_hold",  pmem_rdata, {B4, B3, B2, B1});
    burst_resp = 1'b0;

    // ---------------- 2: write ----------------
    pmem_write = 1'b1; pmem_address = 32'h0000_ABCD; pmem_wdata = {W3, W2, W1, W0};
    burst_resp = 1'b1;
    tick();
    for (int k = 0; k < 4; k++) begin
      check($sformatf("wr_burst_write_%0d", k), 256'(burst_write), 256'd1);
      check($sformatf("wr_wdata_%0d", k),       256'(burst_wdata), 256'(wr_beats[k]));
      tick();
    end
    check("wr_pmem_resp",    256'(pmem_resp),     256'd1);
    check("wr_write_done",   256'(burst_write),   256'd0);
    check("wr_burst_addr",   256'(burst_address), 256'h0000_ABC0);
    pmem_write = 1'b0; burst_resp = 1'b0;
    tick();
    check("wr_idle_resp",    256'(pmem_resp), 256'd0);

    // ---------------- 3: read with burst_resp gaps ----------------
    begin
      int acc;
      acc = 0;
      pmem_read = 1'b1; pmem_address = 32'h0000_0047;
      tick();
      for (int i = 0; i < 7; i++) begin
        burst_resp  = gap_pat[i];
        burst_rdata = gap_pat[i] ? gap_beats[acc] : JUNK;
        check($sformatf("gap_read_%0d", i), 256'(burst_read),    256'd1);
        check($sformatf("gap_addr_%0d", i), 256'(burst_address), 256'h0000_0040);
        check($sformatf("gap_resp_%0d", i), 256'(pmem_resp),     256'd0);
        if (gap_pat[i]) acc++;
        tick();
      end
      burst_resp = 1'b0;
      check("gap_pmem_resp", 256'(pmem_resp), 256'd1);
      check("gap_rdata",     pmem_rdata, {E3, E2, E1, E0});
      pmem_read = 1'b0;
      tick();
    end

    // ---------------- 4: read and write both high ----------------
    pmem_read = 1'b1; pmem_write = 1'b1; pmem_address = 32'h0000_0100;
    pmem_wdata = {W0, W1, W2, W3};
    burst_resp = 1'b1;
    tick();
    for (int k = 0; k < 4; k++) begin
      check($sformatf("both_read_%0d", k),  256'(burst_read),  256'd0);
      check($sformatf("both_write_%0d", k), 256'(burst_write), 256'd1);
      check($sformatf("both_wdata_%0d", k), 256'(burst_wdata), 256'(wr_beats[3-k]));
      tick();
    end
    check("both_pmem_resp", 256'(pmem_resp), 256'd1);
    check("both_rdata_untouched", pmem_rdata, {E3, E2, E1, E0});
    pmem_read = 1'b0; pmem_write = 1'b0; burst_resp = 1'b0;
    tick();

    // ---------------- 5: reset mid-read ----------------
    pmem_read = 1'b1; pmem_address = 32'h0000_0200; burst_resp = 1'b1;
    tick();
    burst_rdata = B4; tick();
    burst_rdata = B3; tick();                 // two beats accepted
    check("mid_read_active", 256'(burst_read), 256'd1);
    rst = 1'b1; pmem_read = 1'b0; burst_resp = 1'b0;
    tick();
    check("mid_rst_read",  256'(burst_read), 256'd0);
    check("mid_rst_resp",  256'(pmem_resp),  256'd0);
    check("mid_rst_rdata", pmem_rdata,       256'd0);
    rst = 1'b0;
    tick();
    pmem_read = 1'b1; pmem_address = 32'h0000_0300; burst_resp = 1'b1;
    tick();
    for (int k = 0; k < 4; k++) begin
      burst_rdata = gap_beats[3-k];
      tick();
    end
    check("fresh_pmem_resp", 256'(pmem_resp),     256'd1);
    check("fresh_addr",      256'(burst_address), 256'h0000_0300);
    check("fresh_rdata",     pmem_rdata, {E0, E1, E2, E3});
    pmem_read = 1'b0; burst_resp = 1'b0;
    tick();

    // ---------------- 6: back-to-back read then write ----------------
    pmem_read = 1'b1; pmem_address = 32'h0000_0420; burst_resp = 1'b1;
    tick();
    for (int k = 0; k < 4; k++) begin
      burst_rdata = rd_beats[3-k];
      tick();
    end
    check("b2b_rd_resp",  256'(pmem_resp), 256'd1);
    check("b2b_rd_rdata", pmem_rdata, {B1, B2, B3, B4});
    pmem_read = 1'b0;                         // burst_resp left high, stray in IDLE
    tick();
    check("b2b_idle_read",  256'(burst_read),  256'd0);
    check("b2b_idle_write", 256'(burst_write), 256'd0);
    tick();
    check("b2b_idle2_resp", 256'(pmem_resp),   256'd0);
    check("b2b_idle2_read", 256'(burst_read),  256'd0);
    pmem_write = 1'b1; pmem_address = 32'h0000_0440; pmem_wdata = {W3, W2, W1, W0};
    tick();
    for (int k = 0; k < 4; k++) begin
      check($sformatf("b2b_wdata_%0d", k), 256'(burst_wdata), 256'(wr_beats[k]));
      tick();
    end
    check("b2b_wr_resp", 256'(pmem_resp), 256'd1);
    pmem_write = 1'b0; burst_resp = 1'b0;
    tick();
    tick();
    check("b2b_final_resp", 256'(pmem_resp), 256'd0);

    // Seven completed requests; the reset-aborted read produces no pulse.
    check("total_resp_pulses", 256'(resp_seen), 256'd7);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule : tb_line_burst_responder
`default_nettype wire
